lut_ctrl: RTL and testbench
===========================

# lut_ctrl

Sequencer and write-port arbiter for the branch-target LUT (W-bit targets, 2**A entries, written as a high part then a low byte). After reset it copies a target table from data memory into the LUT, holding the core stalled. It then passes core read indices through and turns single-cycle core write requests into the LUT's two-cycle hi/lo write sequence.

## Interface
- W, 10, LUT target width; hi part is W-8 bits, taken from Acc bits [W-9:0]
- A, 4, LUT index width; 2**A entries
- BASE, 8'hE0, data-memory byte address of entry 0's hi byte
- clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Mem_Rd  out  1  data-memory read strobe
- Mem_Addr  out  8  data-memory byte address
- Mem_Data  in  8  read data, valid the cycle after Mem_Rd (registered memory)
- Cpu_Imm  in  A  core's LUT read index
- Cpu_Wr_Req  in  1  core write request; held until acked
- Cpu_Wr_Idx  in  A  entry to write
- Cpu_Wr_Data  in  W  target value to write
- Cpu_Wr_Ack  out  1  one-cycle pulse; the write has completed
- Stall  out  1  core must not use Target or issue new work
- Init_Done  out  1  table load complete; sticky until Reset
- Lut_Write_En  out  1  to LUT Write_En
- Lut_Load_Hi  out  1  to LUT Load_Hi (1 = hi part, 0 = low byte)
- Lut_Imm  out  A  to LUT Imm_in
- Lut_Acc  out  8  to LUT Acc_in

## Operation
- FSM states: I_REQ_HI, I_WR_HI, I_REQ_LO, I_WR_LO, READY, W_HI, W_LO. Entry counter is A+1 bits.
- Reset: state I_REQ_HI, counter 0, pending-write flag cleared. During Reset, outputs are forced to:
  - Mem_Rd=0, Lut_Write_En=0, Lut_Load_Hi=0, Lut_Acc=0, Cpu_Wr_Ack=0
  - Stall=1, Init_Done=0
- I_REQ_HI: Mem_Rd=1, Mem_Addr=BASE+2*i.
- I_WR_HI: Lut_Write_En=1, Lut_Load_Hi=1, Lut_Imm=i, Lut_Acc=Mem_Data.
- I_REQ_LO: Mem_Rd=1, Mem_Addr=BASE+2*i+1.
- I_WR_LO: Lut_Write_En=1, Lut_Load_Hi=0, Lut_Imm=i, Lut_Acc=Mem_Data. Then i++; go to READY if i was 2**A-1, else I_REQ_HI.
- Mem_Addr arithmetic is modulo 256 (wraps past 8'hFF). Mem_Addr=0 whenever Mem_Rd=0.
- READY: Stall=0, Init_Done=1, Lut_Imm=Cpu_Imm, Lut_Write_En=0.
  - If Cpu_Wr_Req=1, latch Cpu_Wr_Idx and Cpu_Wr_Data and go to W_HI.
- W_HI: Lut_Write_En=1, Lut_Load_Hi=1, Lut_Imm=latched index, Lut_Acc=zero-extended data[W-1:8]. Stall=1.
- W_LO: Lut_Write_En=1, Lut_Load_Hi=0, Lut_Acc=data[7:0], Cpu_Wr_Ack=1, Stall=1. Next state READY.
- Write requests during init are not dropped. Since Cpu_Wr_Req is held, the request is serviced on the first READY cycle.
- Ack is followed by at least one READY cycle. A request still high then is treated as a new write.
- Stall is 1 in every state except READY.

## Timing
- Init is 4 cycles per entry: 4*2**A cycles after the Reset-deassert edge (64 for A=4).
  - Init_Done rises on cycle 4*2**A; Stall falls the same cycle.
- Runtime write: request sampled in READY at edge n.
  - W_HI in cycle n+1, W_LO/Ack in cycle n+2, READY in cycle n+3.
  - The new Target is readable at cycle n+3.
- Read path is combinational passthrough: Lut_Imm follows Cpu_Imm in READY with zero latency.
- Reset mid-init or mid-write aborts the operation and restarts the load from entry 0.
  - A partially written entry is rewritten by the reload.
  - A write cut off before W_LO is never acked.
- Reset and Cpu_Wr_Req in the same cycle: Reset wins and the request is ignored.

## Test plan
- Init load: memory 0xE0..0xFF = {hi=i&3, lo=0x10+i}, release Reset -> 32 memory reads at 0xE0..0xFF in order; Init_Done rises at cycle 64; Target[i] = {i&3, 0x10+i} for all 16 indices.
- Runtime write: Cpu_Wr_Req with idx 5, data 10'h2A7 in READY -> W_HI drives Acc=0x02, W_LO drives Acc=0xA7, one Ack pulse; Target at idx 5 = 0x2A7 from cycle n+3; Stall high for exactly 2 cycles.
- Request during init: assert Cpu_Wr_Req (idx 3, 10'h155) at cycle 10 -> no Ack until after Init_Done; entry 3 ends as 0x155, not the table value.
- Back-to-back: hold Cpu_Wr_Req across two writes (idx 0 then 15) -> two Acks exactly 3 cycles apart; both entries correct.
- BASE=8'hF8 wrap: entry 4's hi byte read from address 0x00 -> addresses wrap correctly and data lands in entry 4.
- Reset at cycle 30 of init, and again during W_HI -> load restarts at 0xE0; no Ack for the aborted write; Init_Done low until the reload completes.

Source files
------------

// File: rtl/lut_ctrl.sv
// Branch-target LUT sequencer: loads the target table from data memory after reset,
// then passes core read indices through and expands core writes into hi/lo LUT writes.
//
// state    | meaning
// ---------+------------------------------------------------
// I_REQ_HI | read hi byte of entry i from data memory
// I_WR_HI  | write returned hi byte into LUT entry i
// I_REQ_LO | read low byte of entry i from data memory
// I_WR_LO  | write returned low byte, advance to next entry
// READY    | core runs; read index passthrough, accept writes
// W_HI     | core write, hi part
// W_LO     | core write, low byte, ack to core
module lut_ctrl #(
    parameter int W = 10,
    parameter int A = 4,
    parameter logic [7:0] BASE = 8'hE0
) (
    input  logic         clk,
    input  logic         Reset,
    output logic         Mem_Rd,
    output logic [7:0]   Mem_Addr,
    input  logic [7:0]   Mem_Data,
    input  logic [A-1:0] Cpu_Imm,
    input  logic         Cpu_Wr_Req,
    input  logic [A-1:0] Cpu_Wr_Idx,
    input  logic [W-1:0] Cpu_Wr_Data,
    output logic         Cpu_Wr_Ack,
    output logic         Stall,
    output logic         Init_Done,
    output logic         Lut_Write_En,
    output logic         Lut_Load_Hi,
    output logic [A-1:0] Lut_Imm,
    output logic [7:0]   Lut_Acc
);

    typedef enum logic [2:0] {
        I_REQ_HI,
        I_WR_HI,
        I_REQ_LO,
        I_WR_LO,
        READY,
        W_HI,
        W_LO
    } state_t;

    state_t       state_q, state_d;
    logic [A:0]   cnt_q, cnt_d;
    logic         wr_pend_q, wr_pend_d;
    logic [A-1:0] wr_idx_q, wr_idx_d;
    logic [W-1:0] wr_data_q, wr_data_d;

    logic [A-1:0] ent_idx;
    logic [7:0]   hi_addr;

    assign ent_idx = cnt_q[A-1:0];
    // 8-bit add wraps naturally past 8'hFF
    assign hi_addr = BASE + 8'({ent_idx, 1'b0});

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= I_REQ_HI;
            cnt_q     <= '0;
            wr_pend_q <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_pend_q <= wr_pend_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_pend_d    = wr_pend_q;
        wr_idx_d     = wr_idx_q;
        wr_data_d    = wr_data_q;
        Mem_Rd       = 1'b0;
        Mem_Addr     = 8'd0;
        Lut_Write_En = 1'b0;
        Lut_Load_Hi  = 1'b0;
        Lut_Imm      = ent_idx;
        Lut_Acc      = 8'd0;
        Cpu_Wr_Ack   = 1'b0;
        Stall        = 1'b1;
        Init_Done    = 1'b0;

        case (state_q)
            I_REQ_HI: begin
                Mem_Rd   = 1'b1;
                Mem_Addr = hi_addr;
                state_d  = I_WR_HI;
            end
            I_WR_HI: begin
                Lut_Write_En = 1'b1;
                Lut_Load_Hi  = 1'b1;
                Lut_Acc      = Mem_Data;
                state_d      = I_REQ_LO;
            end
            I_REQ_LO: begin
                Mem_Rd   = 1'b1;
                Mem_Addr = hi_addr + 8'd1;
                state_d  = I_WR_LO;
            end
            I_WR_LO: begin
                Lut_Write_En = 1'b1;
                Lut_Acc      = Mem_Data;
                cnt_d        = cnt_q + (A+1)'(1);
                state_d      = (ent_idx == '1) ? READY : I_REQ_HI;
            end
            READY: begin
                Stall     = 1'b0;
                Init_Done = 1'b1;
                Lut_Imm   = Cpu_Imm;
                if (Cpu_Wr_Req) begin
                    wr_pend_d = 1'b1;
                    wr_idx_d  = Cpu_Wr_Idx;
                    wr_data_d = Cpu_Wr_Data;
                    state_d   = W_HI;
                end
            end
            W_HI: begin
                Init_Done    = 1'b1;
                Lut_Write_En = 1'b1;
                Lut_Load_Hi  = 1'b1;
                Lut_Imm      = wr_idx_q;
                Lut_Acc      = 8'(wr_data_q[W-1:8]);
                state_d      = W_LO;
            end
            W_LO: begin
                Init_Done    = 1'b1;
                Lut_Write_En = 1'b1;
                Lut_Imm      = wr_idx_q;
                Lut_Acc      = wr_data_q[7:0];
                Cpu_Wr_Ack   = wr_pend_q;
                wr_pend_d    = 1'b0;
                state_d      = READY;
            end
            default: state_d = I_REQ_HI;
        endcase

        // Reset masks every side effect in the cycle it is asserted
        if (Reset) begin
            Mem_Rd       = 1'b0;
            Mem_Addr     = 8'd0;
            Lut_Write_En = 1'b0;
            Lut_Load_Hi  = 1'b0;
            Lut_Acc      = 8'd0;
            Cpu_Wr_Ack   = 1'b0;
            Stall        = 1'b1;
            Init_Done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_ctrl.sv
// Bench for lut_ctrl: registered memory and LUT models around two DUTs (BASE 8'hE0
// and a wrapping BASE 8'hF8); the target table is predicted from memory contents.
module tb_lut_ctrl;
    localparam int W = 10;
    localparam int A = 4;
    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         Reset;
    logic [A-1:0] Cpu_Imm, Cpu_Wr_Idx;
    logic         Cpu_Wr_Req;
    logic [W-1:0] Cpu_Wr_Data;

    logic         mem_rd_a, ack_a, stall_a, done_a, we_a, hi_a;
    logic [7:0]   mem_addr_a, acc_a, mem_data_a;
    logic [A-1:0] imm_a;
    logic         mem_rd_b, ack_b, stall_b, done_b, we_b, hi_b;
    logic [7:0]   mem_addr_b, acc_b, mem_data_b;
    logic [A-1:0] imm_b;

    lut_ctrl #(.W(W), .A(A), .BASE(8'hE0)) dut (
        .clk(clk), .Reset(Reset), .Mem_Rd(mem_rd_a), .Mem_Addr(mem_addr_a),
        .Mem_Data(mem_data_a), .Cpu_Imm(Cpu_Imm), .Cpu_Wr_Req(Cpu_Wr_Req),
        .Cpu_Wr_Idx(Cpu_Wr_Idx), .Cpu_Wr_Data(Cpu_Wr_Data), .Cpu_Wr_Ack(ack_a),
        .Stall(stall_a), .Init_Done(done_a), .Lut_Write_En(we_a),
        .Lut_Load_Hi(hi_a), .Lut_Imm(imm_a), .Lut_Acc(acc_a)
    );

    lut_ctrl #(.W(W), .A(A), .BASE(8'hF8)) dut_wrap (
        .clk(clk), .Reset(Reset), .Mem_Rd(mem_rd_b), .Mem_Addr(mem_addr_b),
        .Mem_Data(mem_data_b), .Cpu_Imm(Cpu_Imm), .Cpu_Wr_Req(Cpu_Wr_Req),
        .Cpu_Wr_Idx(Cpu_Wr_Idx), .Cpu_Wr_Data(Cpu_Wr_Data), .Cpu_Wr_Ack(ack_b),
        .Stall(stall_b), .Init_Done(done_b), .Lut_Write_En(we_b),
        .Lut_Load_Hi(hi_b), .Lut_Imm(imm_b), .Lut_Acc(acc_b)
    );

    logic [7:0]   mem [256];
    logic [W-1:0] lut_a [N];
    logic [W-1:0] lut_b [N];
    logic [W-1:0] exp_a [N];
    logic [7:0]   rd_log [$];
    int n_tests = 0, n_fail = 0;
    int ack_cnt = 0, addr_bad = 0;

    // Environment: registered data memory and the LUT storage itself
    always @(posedge clk) begin
        if (mem_rd_a) begin
            mem_data_a <= mem[mem_addr_a];
            rd_log.push_back(mem_addr_a);
        end
        if (mem_rd_b) mem_data_b <= mem[mem_addr_b];
        if (!mem_rd_a && mem_addr_a != 8'd0) addr_bad <= addr_bad + 1;
        if (ack_a) ack_cnt <= ack_cnt + 1;
        if (we_a) begin
            if (hi_a) lut_a[imm_a][W-1:8] <= acc_a[W-9:0];
            else      lut_a[imm_a][7:0]   <= acc_a;
        end
        if (we_b) begin
            if (hi_b) lut_b[imm_b][W-1:8] <= acc_b[W-9:0];
            else      lut_b[imm_b][7:0]   <= acc_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_entry(input int base, input int i);
        int h = (base + 2*i) % 256;
        int l = (base + 2*i + 1) % 256;
        return {mem[h][W-9:0], mem[l]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 0 after Reset release; returns at the negedge of the Init_Done cycle
    task automatic wait_init(input int start, output int cyc, output int stall_low);
        cyc = start;
        stall_low = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (done_a) break;
            if (!stall_a) stall_low++;
            cyc++;
        end
    endtask

    task automatic check_reads();
        check("rd_count", rd_log.size(), 32);
        for (int k = 0; k < 32; k++)
            check("rd_addr", (k < rd_log.size()) ? rd_log[k] : 8'hXX, 224 + k);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < N; i++) check(tag, lut_a[i], exp_a[i]);
    endtask

    // Entered at posedge+1 of a READY cycle
    task automatic do_write(input logic [A-1:0] idx, input logic [W-1:0] d);
        int a0 = ack_cnt;
        Cpu_Wr_Req = 1'b1; Cpu_Wr_Idx = idx; Cpu_Wr_Data = d;
        #1;
        check("wr_ready_stall", stall_a, 0);
        tick();
        check("whi_outs", {stall_a, we_a, hi_a, ack_a, imm_a, acc_a},
              {1'b1, 1'b1, 1'b1, 1'b0, idx, 6'b0, d[9:8]});
        tick();
        check("wlo_outs", {stall_a, we_a, hi_a, ack_a, imm_a, acc_a},
              {1'b1, 1'b1, 1'b0, 1'b1, idx, d[7:0]});
        Cpu_Wr_Req = 1'b0;
        tick();
        exp_a[idx] = d;
        Cpu_Imm = idx;
        #1;
        check("wr_stall_after", stall_a, 0);
        check("wr_target", lut_a[imm_a], d);
        check("wr_one_ack", ack_cnt - a0, 1);
    endtask

    initial begin
        int cyc, sl, ac0, first, second, nacks, k;
        logic [W-1:0] d0, d1;
        Reset = 1'b1; Cpu_Wr_Req = 1'b0; Cpu_Imm = '0; Cpu_Wr_Idx = '0; Cpu_Wr_Data = '0;
        for (int m = 0; m < 256; m++) mem[m] = 8'($urandom);
        for (int i = 0; i < N; i++) begin
            mem[224 + 2*i]     = 8'(i & 3);
            mem[224 + 2*i + 1] = 8'(16 + i);
        end

        // Reset state
        tick(); tick();
        check("rst_stall", stall_a, 1);
        check("rst_done", done_a, 0);
        check("rst_outs", {mem_rd_a, we_a, hi_a, ack_a, acc_a}, 0);

        // Initial load
        Reset = 1'b0; rd_log.delete();
        wait_init(0, cyc, sl);
        check("init_cycles", cyc, 64);
        check("stall_low_in_init", sl, 0);
        check("stall_at_done", stall_a, 0);
        check_reads();
        for (int i = 0; i < N; i++) begin
            exp_a[i] = exp_entry(224, i);
            check("init_plan_tgt", lut_a[i], {2'(i & 3), 8'(16 + i)});
            check("wrap_tgt", lut_b[i], exp_entry(248, i));
        end
        check("wrap_e4_hi_from_00", lut_b[4][9:8], mem[0][1:0]);

        // Combinational read passthrough
        repeat (4) begin
            Cpu_Imm = 4'($urandom);
            #1;
            check("imm_pass", imm_a, Cpu_Imm);
        end

        // Runtime writes: directed then random
        tick();
        do_write(4'd5, 10'h2A7);
        repeat (4) do_write(4'($urandom), 10'($urandom));
        check_table("after_writes");

        // Back-to-back writes with the request held
        ac0 = ack_cnt; first = -1; second = -1; nacks = 0;
        d0 = 10'($urandom); d1 = 10'($urandom);
        Cpu_Wr_Req = 1'b1; Cpu_Wr_Idx = 4'd0; Cpu_Wr_Data = d0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ack_a) begin
                if (nacks == 0) begin
                    first = c; Cpu_Wr_Idx = 4'd15; Cpu_Wr_Data = d1;
                end else begin
                    second = c; Cpu_Wr_Req = 1'b0;
                end
                nacks++;
            end
        end
        exp_a[0] = d0; exp_a[15] = d1;
        check("b2b_acks", nacks, 2);
        check("b2b_ack_total", ack_cnt - ac0, 2);
        check("b2b_gap", second - first, 3);
        check("b2b_e0", lut_a[0], d0);
        check("b2b_e15", lut_a[15], d1);

        // Write request raised during init
        for (int m = 0; m < 256; m++) mem[m] = 8'($urandom);
        Reset = 1'b1; tick(); Reset = 1'b0; rd_log.delete(); ac0 = ack_cnt;
        repeat (10) tick();
        Cpu_Wr_Req = 1'b1; Cpu_Wr_Idx = 4'd3; Cpu_Wr_Data = 10'h155;
        wait_init(10, cyc, sl);
        check("init2_cycles", cyc, 64);
        check("no_ack_during_init", ack_cnt - ac0, 0);
        k = 0;
        while (k < 10 && !ack_a) begin
            @(negedge clk);
            k++;
        end
        check("init_req_ack_delay", k, 2);
        tick();
        Cpu_Wr_Req = 1'b0;
        check("init_req_acks", ack_cnt - ac0, 1);
        for (int i = 0; i < N; i++) exp_a[i] = (i == 3) ? 10'h155 : exp_entry(224, i);
        check_table("init_req_table");

        // Reset at cycle 30 of init
        for (int m = 0; m < 256; m++) mem[m] = 8'($urandom);
        Reset = 1'b1; tick(); Reset = 1'b0;
        repeat (30) tick();
        Reset = 1'b1;
        #1;
        check("mid_init_rst_outs", {mem_rd_a, we_a, ack_a, stall_a, done_a}, 5'b00010);
        tick();
        Reset = 1'b0; rd_log.delete();
        wait_init(0, cyc, sl);
        check("reload_cycles", cyc, 64);
        check_reads();
        for (int i = 0; i < N; i++) exp_a[i] = exp_entry(224, i);
        check_table("reload_table");

        // Reset during W_HI with the request still high
        tick();
        ac0 = ack_cnt;
        Cpu_Wr_Req = 1'b1; Cpu_Wr_Idx = 4'($urandom); Cpu_Wr_Data = ~exp_a[Cpu_Wr_Idx];
        tick();
        Reset = 1'b1;
        #1;
        check("whi_rst_outs", {we_a, hi_a, acc_a, ack_a, stall_a, done_a}, 13'b0_0000_0000_0010);
        tick();
        Reset = 1'b0; Cpu_Wr_Req = 1'b0; rd_log.delete();
        wait_init(0, cyc, sl);
        check("whi_reload_cycles", cyc, 64);
        check("aborted_write_no_ack", ack_cnt - ac0, 0);
        check_reads();
        check_table("whi_reload_table");

        check("addr_zero_when_idle", addr_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
